// File: rtl/utx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : utx_feeder
// Description : Word FIFO feeding the two-byte UART transmitter. Issues one
//               word at a time (tx_vld_o strobe) and waits for tx_done_i,
//               with an optional inter-word gap timed on the 1 us strobe.
//               Optional feature macro: UTX_FEED_TIMEOUT_EN (WAIT timeout,
//               reported on the sticky tmo_o flag).
// Revision    : 1.0 - initial release
// ============================================================================
module utx_feeder #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_US     = 0,
    parameter int TIMEOUT_US = 250
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  pluse_us_i,
    input  logic [15:0]           wr_data_i,
    input  logic                  wr_en_i,
    input  logic                  clr_err_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  ovf_o,
    output logic                  tmo_o,
    output logic                  busy_o,
    output logic [15:0]           tx_data_o,
    output logic                  tx_vld_o,
    input  logic                  tx_done_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int c_DEPTH_N = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   c_LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam int c_GW = (GAP_US < 2) ? 1 : $clog2(GAP_US);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_US - 1);
    localparam logic [c_GW-1:0] c_GAP_ONE  = c_GW'(1);
    // State entered after a word completes (or times out)
    localparam state_t c_AFTER = (GAP_US > 0) ? ST_GAP : ST_IDLE;

    logic [15:0]           mem_q [c_DEPTH_N];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  full_q, empty_q, ovf_q, busy_q, tx_vld_q;
    logic [15:0]           tx_data_q;
    logic [c_GW-1:0]       gap_cnt_q;
    state_t                state_q, state_d;
    logic                  w_push, w_pop, w_ovf_evt;

    // A write while full is dropped even if a pop happens in the same cycle
    assign w_push    = wr_en_i && !full_q;
    assign w_ovf_evt = wr_en_i && full_q;

`ifdef UTX_FEED_TIMEOUT_EN
    localparam int c_TW = (TIMEOUT_US < 2) ? 1 : $clog2(TIMEOUT_US);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT_US - 1);
    localparam logic [c_TW-1:0] c_TMO_ONE  = c_TW'(1);
    logic [c_TW-1:0] tmo_cnt_q;
    logic            tmo_q, w_tmo_hit, w_tmo_evt;

    // Fires on the TIMEOUT_US-th strobe spent in WAIT
    assign w_tmo_hit = (state_q == ST_WAIT) && pluse_us_i && (tmo_cnt_q == c_TMO_LAST);

    // WAIT-time counter, restarted on every issue
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if (w_pop)
                tmo_cnt_q <= '0;
            else if (state_q == ST_WAIT && pluse_us_i)
                tmo_cnt_q <= tmo_cnt_q + c_TMO_ONE;
            tmo_q <= (tmo_q && !clr_err_i) || w_tmo_evt;
        end
    end
    assign tmo_o = tmo_q;
`else
    assign tmo_o = 1'b0;
`endif

    // Next-state logic; issue happens only on the IDLE->WAIT transition
    always_comb begin
        state_d = state_q;
        w_pop   = 1'b0;
`ifdef UTX_FEED_TIMEOUT_EN
        w_tmo_evt = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!empty_q) begin
                    w_pop   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done_i)
                    state_d = c_AFTER;
`ifdef UTX_FEED_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    state_d   = c_AFTER;
                    w_tmo_evt = 1'b1;
                end
`endif
            end
            ST_GAP: begin
                if (pluse_us_i && gap_cnt_q == c_GAP_LAST)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Occupancy bookkeeping: simultaneous push and pop leave level unchanged
    always_comb begin
        level_d = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + c_LVL_ONE;
            2'b01:   level_d = level_q - c_LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk_sys) begin
        if (w_push)
            mem_q[wr_ptr_q] <= wr_data_i;
    end

    // FSM, pointers, flags and registered outputs
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            tx_vld_q  <= 1'b0;
            tx_data_q <= 16'h0000;
            gap_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            full_q   <= (level_d == c_LVL_FULL);
            empty_q  <= (level_d == '0);
            busy_q   <= (state_d != ST_IDLE);
            tx_vld_q <= w_pop;
            ovf_q    <= (ovf_q && !clr_err_i) || w_ovf_evt;
            if (w_push)
                wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            if (w_pop) begin
                rd_ptr_q  <= rd_ptr_q + c_PTR_ONE;
                tx_data_q <= mem_q[rd_ptr_q];
            end
            if (state_q != ST_GAP)
                gap_cnt_q <= '0;
            else if (pluse_us_i)
                gap_cnt_q <= (gap_cnt_q == c_GAP_LAST) ? '0 : gap_cnt_q + c_GAP_ONE;
        end
    end

    assign full_o    = full_q;
    assign empty_o   = empty_q;
    assign level_o   = level_q;
    assign ovf_o     = ovf_q;
    assign busy_o    = busy_q;
    assign tx_vld_o  = tx_vld_q;
    assign tx_data_o = tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_utx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_utx_feeder
// Description : Directed self-checking bench for utx_feeder (DEPTH_LOG2=2,
//               GAP_US=2). Covers the timeout path when UTX_FEED_TIMEOUT_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_utx_feeder;

    localparam int DEPTH_LOG2 = 2;

    logic                clk_sys = 1'b0;
    logic                rst_n = 1'b0;
    logic                pluse_us_i = 1'b0;
    logic [15:0]         wr_data_i = 16'h0;
    logic                wr_en_i = 1'b0;
    logic                clr_err_i = 1'b0;
    logic                tx_done_i = 1'b0;
    logic                full_o, empty_o, ovf_o, tmo_o, busy_o, tx_vld_o;
    logic [DEPTH_LOG2:0] level_o;
    logic [15:0]         tx_data_o;

    int n_chk  = 0;
    int n_fail = 0;

    utx_feeder #(.DEPTH_LOG2(DEPTH_LOG2), .GAP_US(2), .TIMEOUT_US(250)) u_dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .pluse_us_i (pluse_us_i),
        .wr_data_i  (wr_data_i),
        .wr_en_i    (wr_en_i),
        .clr_err_i  (clr_err_i),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .level_o    (level_o),
        .ovf_o      (ovf_o),
        .tmo_o      (tmo_o),
        .busy_o     (busy_o),
        .tx_data_o  (tx_data_o),
        .tx_vld_o   (tx_vld_o),
        .tx_done_i  (tx_done_i)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input logic [15:0] w);
        wr_en_i   = 1'b1;
        wr_data_i = w;
        tick();
        wr_en_i   = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
    endtask

    task automatic strobe();
        pluse_us_i = 1'b1;
        tick();
        pluse_us_i = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_val({tag, "_vld"},   tx_vld_o,  1'b0);
        chk_val({tag, "_data"},  tx_data_o, 16'h0);
        chk_val({tag, "_busy"},  busy_o,    1'b0);
        chk_val({tag, "_full"},  full_o,    1'b0);
        chk_val({tag, "_empty"}, empty_o,   1'b1);
        chk_val({tag, "_level"}, level_o,   3'd0);
        chk_val({tag, "_ovf"},   ovf_o,     1'b0);
        chk_val({tag, "_tmo"},   tmo_o,     1'b0);
    endtask

    initial begin
        repeat (3) tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // Single word: issue visible two cycles after the write cycle
        push(16'hA55A);
        chk_val("single_lvl1", level_o, 3'd1);
        chk_val("single_vld_early", tx_vld_o, 1'b0);
        tick();
        chk_val("single_vld", tx_vld_o, 1'b1);
        chk_val("single_data", tx_data_o, 16'hA55A);
        chk_val("single_lvl0", level_o, 3'd0);
        chk_val("single_busy", busy_o, 1'b1);
        tick();
        chk_val("single_vld_1cyc", tx_vld_o, 1'b0);
        tick();
        tick();
        chk_val("single_busy_wait", busy_o, 1'b1);
        pulse_done();
        chk_val("single_busy_gap", busy_o, 1'b1);
        strobe();
        chk_val("single_busy_gap1", busy_o, 1'b1);
        strobe();
        chk_val("single_idle", busy_o, 1'b0);
        chk_val("single_data_hold", tx_data_o, 16'hA55A);

        // Burst with gap, simultaneous push/pop, order preserved
        push(16'h1111);
        tick();
        chk_val("burst_w1", tx_data_o, 16'h1111);
        push(16'h2222);
        push(16'h3333);
        chk_val("burst_lvl2", level_o, 3'd2);
        tick();
        tick();
        chk_val("burst_no_reissue", tx_vld_o, 1'b0);
        pulse_done();
        strobe();
        tick();
        chk_val("burst_gap_hold", tx_vld_o, 1'b0);
        chk_val("burst_gap_busy", busy_o, 1'b1);
        strobe();
        chk_val("burst_idle_lvl", level_o, 3'd2);
        chk_val("burst_idle_busy", busy_o, 1'b0);
        push(16'h4444);
        chk_val("pp_vld", tx_vld_o, 1'b1);
        chk_val("pp_data", tx_data_o, 16'h2222);
        chk_val("pp_lvl", level_o, 3'd2);
        tick();
        pulse_done();
        strobe();
        strobe();
        tick();
        chk_val("burst_w3", tx_data_o, 16'h3333);
        chk_val("burst_w3_vld", tx_vld_o, 1'b1);
        tick();
        pulse_done();
        strobe();
        strobe();
        tick();
        chk_val("burst_w4", tx_data_o, 16'h4444);
        chk_val("burst_w4_lvl", level_o, 3'd0);
        tick();
        pulse_done();
        strobe();
        strobe();
        tick();

        // Overflow with transmitter stalled in WAIT
        push(16'h5000);
        tick();
        chk_val("ovf_first", tx_data_o, 16'h5000);
        for (int i = 1; i <= 5; i++) begin
            push(16'h5000 + 16'(i));
            if (i == 4) begin
                chk_val("ovf_full4", full_o, 1'b1);
                chk_val("ovf_not_yet", ovf_o, 1'b0);
            end
        end
        chk_val("ovf_lvl", level_o, 3'd4);
        chk_val("ovf_full", full_o, 1'b1);
        chk_val("ovf_flag", ovf_o, 1'b1);
        chk_val("ovf_empty", empty_o, 1'b0);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        chk_val("ovf_clr", ovf_o, 1'b0);
        clr_err_i = 1'b1;
        push(16'h5006);
        clr_err_i = 1'b0;
        chk_val("ovf_clr_and_evt", ovf_o, 1'b1);
        chk_val("ovf_lvl_keep", level_o, 3'd4);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        chk_val("ovf_clr2", ovf_o, 1'b0);

        // Reset during an issue with words queued
        pulse_done();
        strobe();
        strobe();
        tick();
        chk_val("rmid_data", tx_data_o, 16'h5001);
        chk_val("rmid_vld", tx_vld_o, 1'b1);
        chk_val("rmid_lvl", level_o, 3'd3);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rmid");
        tick();
        rst_n = 1'b1;
        pulse_done();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_val("late_done_vld", tx_vld_o, 1'b0);
        end
        chk_val("late_done_busy", busy_o, 1'b0);
        push(16'h1234);
        tick();
        chk_val("post_rst_data", tx_data_o, 16'h1234);
        chk_val("post_rst_vld", tx_vld_o, 1'b1);

`ifdef UTX_FEED_TIMEOUT_EN
        // No tx_done: abort on the 250th strobe, then next word goes out
        tick();
        repeat (249) begin
            strobe();
            tick();
        end
        chk_val("tmo_before", tmo_o, 1'b0);
        strobe();
        chk_val("tmo_set", tmo_o, 1'b1);
        chk_val("tmo_gap_busy", busy_o, 1'b1);
        push(16'h6001);
        strobe();
        strobe();
        tick();
        chk_val("tmo_next_vld", tx_vld_o, 1'b1);
        chk_val("tmo_next_data", tx_data_o, 16'h6001);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        chk_val("tmo_clr", tmo_o, 1'b0);
`else
        // Without the timeout the FSM stays in WAIT indefinitely
        tick();
        repeat (300) begin
            strobe();
            tick();
        end
        chk_val("notmo_busy", busy_o, 1'b1);
        chk_val("notmo_tmo", tmo_o, 1'b0);
        chk_val("notmo_vld", tx_vld_o, 1'b0);
`endif
        pulse_done();
        strobe();
        strobe();
        chk_val("final_idle", busy_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
